// File: rtl/serial_tx_arbiter.sv
// Round-robin scheduler sharing one UART transmitter among N_REQ byte sources.
// Frame spacing comes from an internal timer, so no busy feedback from the transmitter is needed.
module serial_tx_arbiter #(
  parameter int CLK_FREQ   = 100_000_000,
  parameter int BAUD       = 115_200,
  parameter int N_REQ      = 4,
  parameter int GAP_CYCLES = 0,
  localparam int CLK_MUL      = CLK_FREQ / BAUD,
  localparam int FRAME_CYCLES = 10 * CLK_MUL + GAP_CYCLES,
  localparam int CNT_W        = $clog2(FRAME_CYCLES + 1),
  localparam int ID_W         = $clog2(N_REQ)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N_REQ-1:0]     req_valid,
  input  logic [8*N_REQ-1:0]   req_data,
  input  logic [N_REQ-1:0]     req_lock,
  output logic [N_REQ-1:0]     req_ready,
  output logic [7:0]           tx_data,
  output logic                 tx_txe,
  output logic                 busy,
  output logic [ID_W-1:0]      grant_id
);

  typedef enum logic [1:0] {IDLE, START, WAIT} state_t;

  localparam logic [ID_W:0] N_EXT = (ID_W + 1)'(N_REQ);

  state_t           state;
  logic [ID_W-1:0]  ptr;
  logic             lock;
  logic [CNT_W-1:0] timer;

  logic             found;
  logic [ID_W-1:0]  winner;
  logic [ID_W:0]    idx;
  logic [7:0]       win_byte;
  logic             win_lock;
  logic [ID_W-1:0]  ptr_next;

  always_comb begin
    found     = 1'b0;
    winner    = '0;
    idx       = '0;
    win_byte  = '0;
    win_lock  = 1'b0;
    req_ready = '0;
    // Reset outranks any request, so arbitration is gated by rst as well as state.
    if (!rst && state == IDLE) begin
      if (lock) begin
        found  = req_valid[grant_id];
        winner = grant_id;
      end else begin
        for (int k = 0; k < N_REQ; k++) begin
          idx = {1'b0, ptr} + (ID_W + 1)'(k);
          if (idx >= N_EXT) idx = idx - N_EXT;
          if (!found && req_valid[idx[ID_W-1:0]]) begin
            found  = 1'b1;
            winner = idx[ID_W-1:0];
          end
        end
      end
    end
    for (int i = 0; i < N_REQ; i++) begin
      if (winner == ID_W'(i)) begin
        win_byte = req_data[8*i +: 8];
        win_lock = req_lock[i];
        if (found) req_ready[i] = 1'b1;
      end
    end
  end

  assign ptr_next = (winner == ID_W'(N_REQ - 1)) ? '0 : winner + 1'b1;

  // Timer is loaded in START so that IDLE returns FRAME_CYCLES clocks after acceptance.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      tx_txe   <= 1'b0;
      tx_data  <= 8'h00;
      busy     <= 1'b0;
      grant_id <= '0;
      ptr      <= '0;
      lock     <= 1'b0;
      timer    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (found) begin
            tx_data  <= win_byte;
            grant_id <= winner;
            lock     <= win_lock;
            ptr      <= ptr_next;
            tx_txe   <= 1'b1;
            busy     <= 1'b1;
            state    <= START;
          end
        end
        START: begin
          tx_txe <= 1'b0;
          timer  <= CNT_W'(FRAME_CYCLES - 3);
          state  <= WAIT;
        end
        WAIT: begin
          if (timer == '0) begin
            busy  <= 1'b0;
            state <= IDLE;
          end else begin
            timer <= timer - 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_tx_arbiter.sv
// Directed bench for serial_tx_arbiter: comb arbitration table plus multi-cycle sequences.
// A second instance with GAP_CYCLES=5 shares the inputs to check the wider frame spacing.
module tb_serial_tx_arbiter;

  localparam int FRAME  = 40;
  localparam int FRAME2 = 45;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req_valid;
  logic [31:0] req_data;
  logic [3:0]  req_lock;

  logic [3:0]  ready1, ready2;
  logic [7:0]  txd1, txd2;
  logic        txe1, txe2, busy1, busy2;
  logic [1:0]  gid1, gid2;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  serial_tx_arbiter #(.CLK_FREQ(1_000_000), .BAUD(250_000), .N_REQ(4), .GAP_CYCLES(0)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data), .req_lock(req_lock),
    .req_ready(ready1), .tx_data(txd1), .tx_txe(txe1), .busy(busy1), .grant_id(gid1)
  );

  serial_tx_arbiter #(.CLK_FREQ(1_000_000), .BAUD(250_000), .N_REQ(4), .GAP_CYCLES(5)) dut_gap (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data), .req_lock(req_lock),
    .req_ready(ready2), .tx_data(txd2), .tx_txe(txe2), .busy(busy2), .grant_id(gid2)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic       rst;
    logic [3:0] valid;
    logic [3:0] exp_ready;
  } vec_t;

  vec_t vecs[8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic set_src(input int i, input logic [7:0] d, input logic lk);
    req_data[8*i +: 8] = d;
    req_lock[i]        = lk;
  endtask

  task automatic wait_idle(input int maxc);
    for (int i = 0; i < maxc && busy1; i++) tick();
    check("idle_reached", 32'(busy1), 0);
  endtask

  int t1[5], t2[5];
  logic [7:0] d1[5], d2[5];
  logic [1:0] g1[5];
  int n1, n2, busy_cnt, txe_cnt, bad_cnt, t_prev, t_now;
  logic seen;
  logic [1:0] exp_g[5] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
  logic [7:0] exp_d[5] = '{8'hA0, 8'hA1, 8'hA2, 8'hA3, 8'hA0};

  initial begin
    // Arbitration at ptr=0, lock=0, IDLE; each vector is applied and withdrawn between edges.
    vecs[0] = '{1'b0, 4'b0000, 4'b0000};
    vecs[1] = '{1'b0, 4'b0001, 4'b0001};
    vecs[2] = '{1'b0, 4'b0110, 4'b0010};
    vecs[3] = '{1'b0, 4'b1000, 4'b1000};
    vecs[4] = '{1'b0, 4'b1111, 4'b0001};
    vecs[5] = '{1'b0, 4'b1100, 4'b0100};
    vecs[6] = '{1'b1, 4'b1111, 4'b0000};
    vecs[7] = '{1'b1, 4'b0100, 4'b0000};

    rst = 1'b1; req_valid = '0; req_data = '0; req_lock = '0;
    tick(); tick(); tick();
    check("reset_txe", 32'(txe1), 0);
    check("reset_tx_data", 32'(txd1), 0);
    check("reset_busy", 32'(busy1), 0);
    check("reset_ready", 32'(ready1), 0);
    check("reset_grant_id", 32'(gid1), 0);
    rst = 1'b0;

    for (int v = 0; v < 8; v++) begin
      @(negedge clk);
      rst = vecs[v].rst;
      req_valid = vecs[v].valid;
      #1;
      check($sformatf("table_ready[%0d]", v), 32'(ready1), 32'(vecs[v].exp_ready));
      req_valid = '0;
      rst = 1'b0;
    end
    tick();

    // Single byte from source 2.
    set_src(2, 8'h59, 1'b0);
    req_valid = 4'b0100;
    #1;
    check("single_ready", 32'(ready1), 32'b0100);
    tick();
    req_valid = '0;
    check("single_txe", 32'(txe1), 1);
    check("single_tx_data", 32'(txd1), 32'h59);
    check("single_grant_id", 32'(gid1), 2);
    busy_cnt = 32'(busy1); txe_cnt = 32'(txe1);
    for (int i = 1; i < 60; i++) begin
      tick();
      busy_cnt += 32'(busy1);
      txe_cnt  += 32'(txe1);
    end
    check("single_busy_cycles", busy_cnt, FRAME - 1);
    check("single_txe_count", txe_cnt, 1);

    // Round robin, all sources valid continuously; both instances observed.
    rst = 1'b1; tick(); rst = 1'b0;
    for (int i = 0; i < 4; i++) set_src(i, 8'hA0 + 8'(i), 1'b0);
    req_valid = 4'b1111;
    n1 = 0; n2 = 0; bad_cnt = 0;
    for (int c = 0; c < 300 && (n1 < 5 || n2 < 5); c++) begin
      tick();
      if (txe1 && n1 < 5) begin t1[n1] = cyc; d1[n1] = txd1; g1[n1] = gid1; n1++; end
      if (txe2 && n2 < 5) begin t2[n2] = cyc; d2[n2] = txd2; n2++; end
      if ($countones(ready1) > 1 || (ready1 != 0 && busy1)) bad_cnt++;
    end
    check("rr_pulse_count", n1, 5);
    check("gap_pulse_count", n2, 5);
    check("rr_ready_onehot", bad_cnt, 0);
    for (int i = 0; i < 5; i++) begin
      check($sformatf("rr_grant[%0d]", i), 32'(g1[i]), 32'(exp_g[i]));
      check($sformatf("rr_data[%0d]", i), 32'(d1[i]), 32'(exp_d[i]));
      check($sformatf("gap_data[%0d]", i), 32'(d2[i]), 32'(exp_d[i]));
      if (i > 0) begin
        check($sformatf("rr_spacing[%0d]", i), t1[i] - t1[i-1], FRAME);
        check($sformatf("gap_spacing[%0d]", i), t2[i] - t2[i-1], FRAME2);
      end
    end
    req_valid = '0;

    // Lock: lead-in grant to source 0 moves ptr to 1.
    rst = 1'b1; tick(); rst = 1'b0;
    set_src(0, 8'h0F, 1'b0);
    req_valid = 4'b0001;
    tick();
    req_valid = '0;
    wait_idle(60);
    set_src(1, 8'h10, 1'b1);
    req_valid = 4'b0011;
    #1;
    check("lock_first_ready", 32'(ready1), 32'b0010);
    tick();
    req_valid = 4'b0001;
    check("lock_first_data", 32'(txd1), 32'h10);
    check("lock_first_grant", 32'(gid1), 1);
    bad_cnt = 0;
    for (int i = 0; i < 100; i++) begin
      tick();
      if (ready1 != 0 || txe1) bad_cnt++;
    end
    check("lock_gap_no_grant", bad_cnt, 0);
    set_src(1, 8'h11, 1'b0);
    req_valid = 4'b0011;
    #1;
    check("lock_second_ready", 32'(ready1), 32'b0010);
    tick();
    req_valid = 4'b0001;
    check("lock_second_data", 32'(txd1), 32'h11);
    check("lock_second_txe", 32'(txe1), 1);
    t_prev = cyc;
    seen = 1'b0;
    for (int i = 0; i < 60 && !seen; i++) begin
      tick();
      seen = txe1;
    end
    check("lock_release_seen", 32'(seen), 1);
    check("lock_release_data", 32'(txd1), 32'h0F);
    check("lock_release_grant", 32'(gid1), 0);
    check("lock_release_spacing", cyc - t_prev, FRAME);
    req_valid = '0;
    t_prev = cyc;

    // Late request: source 3 rises at WAIT cycle 20 and waits for IDLE.
    set_src(3, 8'h33, 1'b0);
    bad_cnt = 0;
    for (int i = 1; i < 40; i++) begin
      tick();
      if (i < 39 && ready1 != 0) bad_cnt++;
      if (i == 20) req_valid = 4'b1000;
    end
    check("late_held_off", bad_cnt, 0);
    check("late_ready_first_idle", 32'(ready1), 32'b1000);
    tick();
    req_valid = '0;
    check("late_txe", 32'(txe1), 1);
    check("late_data", 32'(txd1), 32'h33);
    check("late_spacing", cyc - t_prev, FRAME);

    // Reset mid-frame at WAIT cycle 10 with source 0 pending.
    set_src(0, 8'h77, 1'b0);
    req_valid = 4'b0001;
    for (int i = 0; i < 10; i++) tick();
    check("midrst_busy_before", 32'(busy1), 1);
    rst = 1'b1;
    #1;
    check("midrst_ready_in_rst", 32'(ready1), 0);
    tick();
    check("midrst_busy", 32'(busy1), 0);
    check("midrst_tx_data", 32'(txd1), 0);
    check("midrst_txe", 32'(txe1), 0);
    check("midrst_ptr", 32'(dut.ptr), 0);
    rst = 1'b0;
    #1;
    check("midrst_ready_after", 32'(ready1), 32'b0001);
    tick();
    req_valid = '0;
    check("midrst_accept_txe", 32'(txe1), 1);
    check("midrst_accept_data", 32'(txd1), 32'h77);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
